// File: rtl/mod_147_timer_pkg.sv
// rtl/mod_147_timer_pkg.sv - shared state encoding and heartbeat timer constants for the timer bank
package mod_147_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_DONE    = 2'd2
  } chan_state_e;

  localparam int HB_SEND_TIMER = 0;
  localparam int HB_TIMER      = 1;

  // 25 MHz PLCA system clock (40 ns period).
  localparam int unsigned SYS_CLK_PERIOD_NS = 40;

  function automatic int unsigned ns_to_ticks(input longint unsigned ns);
    return int'(ns / SYS_CLK_PERIOD_NS);
  endfunction

  localparam int unsigned HB_SEND_TIMER_TICKS = ns_to_ticks(64'd2000);
  localparam int unsigned HB_TIMER_TICKS      = ns_to_ticks(64'd50_000_000);

endpackage

// File: rtl/mod_147_timer_chan.sv
// rtl/mod_147_timer_chan.sv - one timer channel: IDLE/RUNNING/DONE FSM, prescaler and down-counter
// Optional periodic reload compiled in with TIMER_BANK_PERIODIC_EN.
module mod_147_timer_chan
  import mod_147_timer_pkg::*;
#(
  parameter int CNT_WIDTH = 24,
  parameter int PRESCALE  = 1,
  parameter int PRE_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [CNT_WIDTH-1:0] duration_i,
  input  logic                 periodic_i,
  output logic                 done_o,
  output logic                 not_done_o,
  output logic                 expired_o
);

  localparam logic [PRE_WIDTH-1:0] PRE_MAX = PRE_WIDTH'(PRESCALE - 1);

  chan_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [PRE_WIDTH-1:0] pre_q, pre_d;
  logic                 expired_q, expired_d;
  logic [CNT_WIDTH-1:0] load_val;
  logic                 tick;

  // A zero duration is treated as one tick.
  assign load_val = (duration_i == '0) ? CNT_WIDTH'(1) : duration_i;
  assign tick     = (state_q == ST_RUNNING) && (pre_q == PRE_MAX);

`ifdef TIMER_BANK_PERIODIC_EN
  logic [CNT_WIDTH-1:0] dur_q, dur_d;
  logic                 reload;
  assign reload = periodic_i;
`else
  logic unused_periodic;
  assign unused_periodic = periodic_i;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pre_d     = pre_q;
    expired_d = 1'b0;
`ifdef TIMER_BANK_PERIODIC_EN
    dur_d     = dur_q;
`endif
    if (start_i) begin
      state_d = ST_RUNNING;
      cnt_d   = load_val;
      pre_d   = '0;
`ifdef TIMER_BANK_PERIODIC_EN
      dur_d   = load_val;
`endif
    end else if (stop_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      pre_d   = '0;
    end else if (state_q == ST_RUNNING) begin
      if (tick) begin
        pre_d = '0;
        if (cnt_q <= CNT_WIDTH'(1)) begin
          expired_d = 1'b1;
`ifdef TIMER_BANK_PERIODIC_EN
          if (reload) begin
            cnt_d = dur_q;
          end else begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end
`else
          state_d = ST_DONE;
          cnt_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end else begin
        pre_d = pre_q + PRE_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pre_q     <= '0;
      expired_q <= 1'b0;
`ifdef TIMER_BANK_PERIODIC_EN
      dur_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      expired_q <= expired_d;
`ifdef TIMER_BANK_PERIODIC_EN
      dur_q     <= dur_d;
`endif
    end
  end

  assign done_o     = (state_q == ST_DONE);
  assign not_done_o = (state_q == ST_RUNNING);
  assign expired_o  = expired_q;

endmodule

// File: rtl/mod_147_3_7_1_timer_bank.sv
// rtl/mod_147_3_7_1_timer_bank.sv - bank of NUM_TIMERS independent clock-counted PLCA timers
// Periodic mode per channel available when TIMER_BANK_PERIODIC_EN is defined.
module mod_147_3_7_1_timer_bank
  import mod_147_timer_pkg::*;
#(
  parameter int NUM_TIMERS = 2,
  parameter int CNT_WIDTH  = 24,
  parameter int PRESCALE   = 1,
  parameter int PRE_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_TIMERS-1:0]           timer_start,
  input  logic [NUM_TIMERS-1:0]           timer_stop,
  input  logic [NUM_TIMERS*CNT_WIDTH-1:0] timer_duration,
  input  logic [NUM_TIMERS-1:0]           timer_periodic,
  output logic [NUM_TIMERS-1:0]           timer_done,
  output logic [NUM_TIMERS-1:0]           timer_not_done,
  output logic [NUM_TIMERS-1:0]           timer_expired
);

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_chan
    mod_147_timer_chan #(
      .CNT_WIDTH (CNT_WIDTH),
      .PRESCALE  (PRESCALE),
      .PRE_WIDTH (PRE_WIDTH)
    ) u_chan (
      .clk        (clk),
      .reset_n    (reset_n),
      .start_i    (timer_start[i]),
      .stop_i     (timer_stop[i]),
      .duration_i (timer_duration[i*CNT_WIDTH +: CNT_WIDTH]),
      .periodic_i (timer_periodic[i]),
      .done_o     (timer_done[i]),
      .not_done_o (timer_not_done[i]),
      .expired_o  (timer_expired[i])
    );
  end

endmodule

// File: tb/tb_mod_147_3_7_1_timer_bank.sv
// tb/tb_mod_147_3_7_1_timer_bank.sv - directed self-checking bench for the timer bank (PRESCALE 1 and 4)
module tb_mod_147_3_7_1_timer_bank;

  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    start, stop, periodic;
  logic [2*CW-1:0] dur;
  logic [1:0]    done, not_done, expired;

  logic [1:0]    s4_start, s4_stop, s4_periodic;
  logic [2*CW-1:0] s4_dur;
  logic [1:0]    s4_done, s4_not_done, s4_expired;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mod_147_3_7_1_timer_bank #(.NUM_TIMERS(2), .CNT_WIDTH(CW), .PRESCALE(1), .PRE_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .timer_start(start), .timer_stop(stop),
    .timer_duration(dur), .timer_periodic(periodic), .timer_done(done),
    .timer_not_done(not_done), .timer_expired(expired)
  );

  mod_147_3_7_1_timer_bank #(.NUM_TIMERS(2), .CNT_WIDTH(CW), .PRESCALE(4), .PRE_WIDTH(8)) dut4 (
    .clk(clk), .reset_n(reset_n), .timer_start(s4_start), .timer_stop(s4_stop),
    .timer_duration(s4_dur), .timer_periodic(s4_periodic), .timer_done(s4_done),
    .timer_not_done(s4_not_done), .timer_expired(s4_expired)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [1:0] seen;

  initial begin
    reset_n = 1'b0;
    start = '0; stop = '0; periodic = '0; dur = '0;
    s4_start = '0; s4_stop = '0; s4_periodic = '0; s4_dur = '0;
    step(2);
    check("reset_outputs", {26'd0, done, not_done, expired}, 32'd0);
    reset_n = 1'b1;
    step(2);
    check("idle_after_reset", {26'd0, done, not_done, expired}, 32'd0);

    // stop in IDLE is a no-op
    stop = 2'b01; step(1); stop = '0;
    check("stop_in_idle", {28'd0, done, not_done}, 32'd0);

    // basic expiry, D=5
    dur[0 +: CW] = 24'd5; start = 2'b01; step(1); start = '0;
    check("basic_running", {28'd0, done, not_done}, {28'd0, 2'b00, 2'b01});
    step(4);
    check("basic_before_exp", {26'd0, done, not_done, expired}, {26'd0, 2'b00, 2'b01, 2'b00});
    step(1);
    check("basic_expiry", {26'd0, done, not_done, expired}, {26'd0, 2'b01, 2'b00, 2'b01});
    step(1);
    check("basic_pulse_1cyc", {30'd0, expired}, 32'd0);
    step(10);
    check("basic_done_holds", {28'd0, done, not_done}, {28'd0, 2'b01, 2'b00});
    stop = 2'b01; step(1); stop = '0;
    check("basic_stop_done", {28'd0, done, not_done}, 32'd0);

    // restart on the expiry cycle, D=3
    dur[0 +: CW] = 24'd3; start = 2'b01; step(1); start = '0;
    step(2);
    start = 2'b01; step(1); start = '0;
    check("restart_on_exp", {26'd0, done, not_done, expired}, {26'd0, 2'b00, 2'b01, 2'b00});
    step(2);
    check("restart_pending", {30'd0, done}, 32'd0);
    step(1);
    check("restart_new_exp", {26'd0, done, expired}, {26'd0, 2'b01, 2'b01});

    // start+stop together: start wins
    start = 2'b01; stop = 2'b01; step(1); start = '0; stop = '0;
    check("start_stop_same", {28'd0, done, not_done}, {28'd0, 2'b00, 2'b01});
    stop = 2'b01; step(1); stop = '0;
    check("stop_running", {28'd0, done, not_done}, 32'd0);

    // prescaled: PRESCALE=4, D=3 -> 12 cycles; D=0 -> 4 cycles
    s4_dur[0 +: CW] = 24'd3; s4_start = 2'b01; step(1); s4_start = '0;
    step(11);
    check("pre4_d3_before", {30'd0, s4_done}, 32'd0);
    step(1);
    check("pre4_d3_done", {28'd0, s4_done, s4_expired}, {28'd0, 2'b01, 2'b01});
    s4_dur[0 +: CW] = 24'd0; s4_start = 2'b01; step(1); s4_start = '0;
    step(3);
    check("pre4_d0_before", {28'd0, s4_done, s4_not_done}, {28'd0, 2'b00, 2'b01});
    step(1);
    check("pre4_d0_done", {28'd0, s4_done, s4_expired}, {28'd0, 2'b01, 2'b01});

    // reset mid-count: no pending expiry afterwards
    dur[0 +: CW] = 24'd10; dur[CW +: CW] = 24'd4; start = 2'b11; step(1); start = '0;
    step(3);
    #2 reset_n = 1'b0;
    #1 check("async_reset", {26'd0, done, not_done, expired}, 32'd0);
    step(2);
    reset_n = 1'b1;
    seen = '0;
    for (int k = 0; k < 100; k++) begin
      step(1);
      seen = seen | expired | done | not_done;
    end
    check("no_activity_after_reset", {30'd0, seen}, 32'd0);

    // independent channels
    dur[0 +: CW] = 24'd2000; dur[CW +: CW] = 24'd50000; start = 2'b11; step(1); start = '0;
    step(1999);
    check("ind_1999", {28'd0, done, not_done}, {28'd0, 2'b00, 2'b11});
    step(1);
    check("ind_ch0_exp", {26'd0, done, not_done, expired}, {26'd0, 2'b01, 2'b10, 2'b01});
    stop = 2'b01; step(1); stop = '0;
    check("ind_stop_ch0", {28'd0, done, not_done}, {28'd0, 2'b00, 2'b10});
    step(47998);
    check("ind_49999", {26'd0, done, not_done, expired}, {26'd0, 2'b00, 2'b10, 2'b00});
    step(1);
    check("ind_ch1_exp", {26'd0, done, not_done, expired}, {26'd0, 2'b10, 2'b00, 2'b10});

    // periodic request on ch1, D=7
    dur[CW +: CW] = 24'd7; periodic = 2'b10; start = 2'b10; step(1); start = '0;
    step(7);
`ifdef TIMER_BANK_PERIODIC_EN
    check("per_7", {26'd0, done, not_done, expired}, {26'd0, 2'b00, 2'b10, 2'b10});
    step(7);
    check("per_14", {26'd0, done, not_done, expired}, {26'd0, 2'b00, 2'b10, 2'b10});
    periodic = '0;
    step(7);
    check("per_21_done", {26'd0, done, not_done, expired}, {26'd0, 2'b10, 2'b00, 2'b10});
`else
    check("noper_7", {26'd0, done, not_done, expired}, {26'd0, 2'b10, 2'b00, 2'b10});
    step(7);
    check("noper_14", {26'd0, done, not_done, expired}, {26'd0, 2'b10, 2'b00, 2'b00});
    periodic = '0;
    step(7);
    check("noper_21", {26'd0, done, not_done, expired}, {26'd0, 2'b10, 2'b00, 2'b00});
`endif
    stop = 2'b10; step(1); stop = '0;
    check("per_stop", {28'd0, done, not_done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
